// File: rtl/branch_resolve_if.sv
// ============================================================================
// Module      : branch_resolve_if
// Description : Instruction-in / redirect-out bundle for the branch resolver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface branch_resolve_if #(
    parameter int PC_W = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      opcode;
    logic [1:0]      flags_in;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] branch_target;
    logic [PC_W-1:0] ra_value;
    logic            out_valid;
    logic            out_ready;
    logic            taken;
    logic [PC_W-1:0] next_pc;
    logic            ra_we;
    logic [PC_W-1:0] ra_wdata;
    logic            flush;
    logic            gt_flag;
    logic            eq_flag;

    modport master (
        output in_valid, opcode, flags_in, pc, branch_target, ra_value, out_ready,
        input  in_ready, out_valid, taken, next_pc, ra_we, ra_wdata, flush, gt_flag, eq_flag
    );

    modport slave (
        input  in_valid, opcode, flags_in, pc, branch_target, ra_value, out_ready,
        output in_ready, out_valid, taken, next_pc, ra_we, ra_wdata, flush, gt_flag, eq_flag
    );
endinterface

`default_nettype wire

// File: rtl/branch_resolve.sv
// ============================================================================
// Module      : branch_resolve
// Description : Execute-stage branch resolution with flags register and squash.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_resolve #(
    parameter int PC_W         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    branch_resolve_if.slave  bus
);
    localparam logic [4:0] OP_CMP  = 5'b00101;
    localparam logic [4:0] OP_BEQ  = 5'b10000;
    localparam logic [4:0] OP_BGT  = 5'b10001;
    localparam logic [4:0] OP_B    = 5'b10010;
    localparam logic [4:0] OP_CALL = 5'b10011;
    localparam logic [4:0] OP_RET  = 5'b10100;
    localparam logic [2:0] FLUSH_CNT = 3'(FLUSH_CYCLES);

    typedef enum logic [0:0] {
        S_RUN    = 1'b0,
        S_SQUASH = 1'b1
    } state_t;

    state_t          state_q;
    logic [2:0]      cnt_q;
    logic            out_valid_q;
    logic            taken_q;
    logic [PC_W-1:0] next_pc_q;
    logic            ra_we_q;
    logic [PC_W-1:0] ra_wdata_q;
    logic            flush_q;
    logic            gt_q;
    logic            eq_q;

    logic            in_ready_w;
    logic            accept_run_w;
    logic            is_cmp_w;
    logic            is_call_w;
    logic            taken_d;
    logic [PC_W-1:0] next_pc_d;

    // Squash beats are always consumed, independent of output back-pressure.
    assign in_ready_w   = (state_q == S_SQUASH) || !out_valid_q || bus.out_ready;
    assign accept_run_w = (state_q == S_RUN) && bus.in_valid && in_ready_w;
    assign is_cmp_w     = (bus.opcode == OP_CMP);
    assign is_call_w    = (bus.opcode == OP_CALL);

    always_comb begin
        taken_d   = 1'b0;
        next_pc_d = bus.branch_target;
        case (bus.opcode)
            OP_B, OP_CALL: taken_d = 1'b1;
            OP_BEQ:        taken_d = eq_q;
            OP_BGT:        taken_d = gt_q;
            OP_RET: begin
                taken_d   = 1'b1;
                next_pc_d = bus.ra_value;
            end
            default:       taken_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RUN;
            cnt_q       <= 3'd0;
            out_valid_q <= 1'b0;
            taken_q     <= 1'b0;
            next_pc_q   <= '0;
            ra_we_q     <= 1'b0;
            ra_wdata_q  <= '0;
            flush_q     <= 1'b0;
            gt_q        <= 1'b0;
            eq_q        <= 1'b0;
        end else begin
            // Clearing taken/ra_we on drain keeps a stale call from writing RA twice.
            if (bus.out_ready) begin
                out_valid_q <= 1'b0;
                taken_q     <= 1'b0;
                ra_we_q     <= 1'b0;
            end
            case (state_q)
                S_RUN: begin
                    if (accept_run_w) begin
                        out_valid_q <= 1'b1;
                        taken_q     <= taken_d;
                        next_pc_q   <= next_pc_d;
                        ra_we_q     <= is_call_w;
                        ra_wdata_q  <= bus.pc + PC_W'(4);
                        if (is_cmp_w) begin
                            gt_q <= bus.flags_in[1];
                            eq_q <= bus.flags_in[0];
                        end
                        if (taken_d) begin
                            state_q <= S_SQUASH;
                            cnt_q   <= FLUSH_CNT;
                            flush_q <= 1'b1;
                        end
                    end
                end
                S_SQUASH: begin
                    if (bus.in_valid) begin
                        cnt_q <= cnt_q - 3'd1;
                        if (cnt_q == 3'd1) begin
                            state_q <= S_RUN;
                            flush_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= S_RUN;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_q;
    assign bus.taken     = taken_q;
    assign bus.next_pc   = next_pc_q;
    assign bus.ra_we     = ra_we_q;
    assign bus.ra_wdata  = ra_wdata_q;
    assign bus.flush     = flush_q;
    assign bus.gt_flag   = gt_q;
    assign bus.eq_flag   = eq_q;

endmodule

`default_nettype wire
